// File: rtl/apb_uart_pkg.sv
// Shared definitions for the APB UART bridge: register map, STATUS/CTRL bit positions,
// TX FSM state type and a level-saturation helper.
package apb_uart_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_RXDATA = 4'h4;
    localparam logic [3:0] ADDR_STATUS = 4'h8;
    localparam logic [3:0] ADDR_CTRL   = 4'hC;

    localparam int unsigned ST_TX_LEVEL_LSB = 0;
    localparam int unsigned ST_RX_LEVEL_LSB = 8;
    localparam int unsigned ST_TX_EMPTY     = 16;
    localparam int unsigned ST_TX_FULL      = 17;
    localparam int unsigned ST_RX_EMPTY     = 18;
    localparam int unsigned ST_RX_FULL      = 19;
    localparam int unsigned ST_RX_OVF       = 20;
    localparam int unsigned ST_RX_FERR      = 21;

    localparam int unsigned CTRL_TX_EN  = 0;
    localparam int unsigned CTRL_RX_EN  = 1;
    localparam int unsigned CTRL_IE_RX  = 2;
    localparam int unsigned CTRL_IE_TX  = 3;
    localparam int unsigned CTRL_IE_ERR = 4;
    localparam int unsigned CTRL_W      = 5;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitDone
    } tx_state_e;

    // STATUS level fields are 6 bits wide; deeper FIFOs clamp at 63.
    function automatic logic [5:0] sat_level(input logic [15:0] lvl);
        return (lvl > 16'd63) ? 6'd63 : lvl[5:0];
    endfunction

endpackage

// File: rtl/apb_uart_byte_fifo.sv
// Byte FIFO that can push up to WR_BYTES and pop up to RD_BYTES bytes per cycle.
// A push is taken only if the space existed before the cycle; a pop only if enough bytes exist.
module apb_uart_byte_fifo
    import apb_uart_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WR_BYTES = 4,
    parameter int unsigned RD_BYTES = 4,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned LW      = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            push_cnt,
    input  logic [8*WR_BYTES-1:0] wdata,
    input  logic [2:0]            pop_cnt,
    output logic [8*RD_BYTES-1:0] rdata,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, free;
    logic          do_push, do_pop;

    assign free    = LW'(DEPTH) - level_q;
    assign do_push = (push_cnt != 3'd0) && (free >= LW'(push_cnt));
    assign do_pop  = (pop_cnt != 3'd0) && (level_q >= LW'(pop_cnt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(push_cnt);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(pop_cnt);
            level_q <= level_q + (do_push ? LW'(push_cnt) : '0) - (do_pop ? LW'(pop_cnt) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int i = 0; i < int'(WR_BYTES); i++) begin
                if (i < int'(push_cnt)) mem[wr_ptr_q + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(RD_BYTES); i++) begin
            rdata[8*i +: 8] = mem[rd_ptr_q + AW'(i)];
        end
    end

    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/apb_uart_bridge.sv
// APB slave bridging word accesses to byte-wide UART TX/RX FIFOs with a TX handshake FSM.
// Optional APB_UART_PSLVERR_EN: stalls and undefined offsets return pslverr instead of waiting.
module apb_uart_bridge
    import apb_uart_pkg::*;
#(
    parameter int unsigned TX_DEPTH       = 16,
    parameter int unsigned RX_DEPTH       = 16,
    parameter int unsigned BYTES_PER_WORD = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        rx_err,
    output logic        tx_en,
    output logic        rx_en,
    output logic        irq
);

    localparam int unsigned TXLW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RXLW = $clog2(RX_DEPTH) + 1;
    localparam logic [2:0]  BPW  = 3'(BYTES_PER_WORD);

    logic [TXLW-1:0]   tx_level;
    logic              tx_full, tx_empty;
    logic [7:0]        tx_head;
    logic [RXLW-1:0]   rx_level;
    logic              rx_full, rx_empty;
    logic [31:0]       rx_rdata;
    logic [CTRL_W-1:0] ctrl_q;
    logic              rx_ovf_q, rx_ferr_q;
    tx_state_e         tx_state_q;

    logic        access, stall, err, done;
    logic        tx_room, rx_avail;
    logic        wr_tx, rd_rx, wr_status, wr_ctrl;
    logic        rx_fire;
    logic [31:0] status_word;

    assign access   = psel & penable;
    assign tx_room  = (TXLW'(TX_DEPTH) - tx_level) >= TXLW'(BPW);
    assign rx_avail = rx_level >= RXLW'(BPW);
    assign stall    = (pwrite && (paddr == ADDR_TXDATA) && !tx_room) ||
                      (!pwrite && (paddr == ADDR_RXDATA) && !rx_avail);

`ifdef APB_UART_PSLVERR_EN
    logic addr_valid;
    assign addr_valid = (paddr == ADDR_TXDATA) || (paddr == ADDR_RXDATA) ||
                        (paddr == ADDR_STATUS) || (paddr == ADDR_CTRL);
    assign err        = stall | ~addr_valid;
    assign pready     = rst_n & access;
    assign pslverr    = rst_n & access & err;
`else
    assign err        = 1'b0;
    assign pready     = rst_n & access & ~stall;
    assign pslverr    = 1'b0;
`endif

    // An access has side effects only in the cycle it completes without error.
    assign done      = pready & ~err;
    assign wr_tx     = done & pwrite & (paddr == ADDR_TXDATA);
    assign rd_rx     = done & ~pwrite & (paddr == ADDR_RXDATA);
    assign wr_status = done & pwrite & (paddr == ADDR_STATUS);
    assign wr_ctrl   = done & pwrite & (paddr == ADDR_CTRL);
    assign rx_fire   = rx_done & ctrl_q[CTRL_RX_EN];

    apb_uart_byte_fifo #(
        .DEPTH    (TX_DEPTH),
        .WR_BYTES (4),
        .RD_BYTES (1)
    ) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_cnt (wr_tx ? BPW : 3'd0),
        .wdata    (pwdata),
        .pop_cnt  ((tx_state_q == StLoad) ? 3'd1 : 3'd0),
        .rdata    (tx_head),
        .level    (tx_level),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    apb_uart_byte_fifo #(
        .DEPTH    (RX_DEPTH),
        .WR_BYTES (1),
        .RD_BYTES (4)
    ) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_cnt ((rx_fire && !rx_full) ? 3'd1 : 3'd0),
        .wdata    (rx_data),
        .pop_cnt  (rd_rx ? BPW : 3'd0),
        .rdata    (rx_rdata),
        .level    (rx_level),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_TX_LEVEL_LSB +: 6] = sat_level(16'(tx_level));
        status_word[ST_RX_LEVEL_LSB +: 6] = sat_level(16'(rx_level));
        status_word[ST_TX_EMPTY]          = tx_empty;
        status_word[ST_TX_FULL]           = tx_full;
        status_word[ST_RX_EMPTY]          = rx_empty;
        status_word[ST_RX_FULL]           = rx_full;
        status_word[ST_RX_OVF]            = rx_ovf_q;
        status_word[ST_RX_FERR]           = rx_ferr_q;
    end

    always_comb begin
        prdata = '0;
        if (done && !pwrite) begin
            case (paddr)
                ADDR_RXDATA: begin
                    for (int i = 0; i < 4; i++) begin
                        if (i < int'(BYTES_PER_WORD)) prdata[8*i +: 8] = rx_rdata[8*i +: 8];
                    end
                end
                ADDR_STATUS: prdata = status_word;
                ADDR_CTRL:   prdata[CTRL_W-1:0] = ctrl_q;
                default:     prdata = '0;
            endcase
        end
    end

    // New error events win over a simultaneous write-one-to-clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            rx_ovf_q  <= 1'b0;
            rx_ferr_q <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_q <= pwdata[CTRL_W-1:0];
            rx_ovf_q  <= (rx_ovf_q & ~(wr_status & pwdata[ST_RX_OVF])) | (rx_fire & rx_full);
            rx_ferr_q <= (rx_ferr_q & ~(wr_status & pwdata[ST_RX_FERR])) | (rx_fire & rx_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= StIdle;
            tx_data    <= 8'h00;
            tx_start   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (tx_state_q)
                StIdle: begin
                    if (ctrl_q[CTRL_TX_EN] && !tx_empty) tx_state_q <= StLoad;
                end
                StLoad: begin
                    tx_data    <= tx_head;
                    tx_start   <= 1'b1;
                    tx_state_q <= StWaitDone;
                end
                StWaitDone: begin
                    if (tx_done) tx_state_q <= StIdle;
                end
                default: tx_state_q <= StIdle;
            endcase
        end
    end

    assign tx_en = ctrl_q[CTRL_TX_EN];
    assign rx_en = ctrl_q[CTRL_RX_EN];
    assign irq   = (ctrl_q[CTRL_IE_RX] & rx_avail) |
                   (ctrl_q[CTRL_IE_TX] & tx_empty) |
                   (ctrl_q[CTRL_IE_ERR] & (rx_ovf_q | rx_ferr_q));

endmodule

// File: tb/tb_apb_uart_bridge.sv
// Self-checking bench for apb_uart_bridge: queue-based reference model of the FIFOs,
// sticky bits and interrupt equation, with a UART transmitter responder.
`timescale 1ns/1ps
module tb_apb_uart_bridge;

    localparam int TXD = 16;
    localparam int RXD = 16;
    localparam int BPW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  paddr = 4'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0, rx_err = 1'b0;
    logic        tx_en, rx_en, irq;

    always #5 clk = ~clk;

    apb_uart_bridge #(
        .TX_DEPTH       (TXD),
        .RX_DEPTH       (RXD),
        .BYTES_PER_WORD (BPW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_err   (rx_err),
        .tx_en    (tx_en),
        .rx_en    (rx_en),
        .irq      (irq)
    );

    // Reference model state
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];
    logic [4:0] m_ctrl = 5'd0;
    bit         m_ovf = 1'b0, m_ferr = 1'b0;
    int         checks = 0, failures = 0;
    int         done_delay = 0;
    bit         auto_done = 1'b1;

    // UART transmitter stand-in: records each started byte, answers with tx_done later.
    always begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
            tx_log.push_back(tx_data);
            if (auto_done) begin
                repeat ((done_delay == 0) ? $urandom_range(1, 4) : done_delay) @(negedge clk);
                tx_done = 1'b1;
                @(negedge clk);
                tx_done = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int tl, rl;
        s  = '0;
        tl = tx_q.size();
        rl = rx_q.size();
        s[5:0]  = 6'((tl > 63) ? 63 : tl);
        s[13:8] = 6'((rl > 63) ? 63 : rl);
        s[16]   = (tl == 0);
        s[17]   = (tl == TXD);
        s[18]   = (rl == 0);
        s[19]   = (rl == RXD);
        s[20]   = m_ovf;
        s[21]   = m_ferr;
        return s;
    endfunction

    function automatic logic exp_irq();
        return (m_ctrl[2] && rx_q.size() >= BPW) || (m_ctrl[3] && tx_q.size() == 0) ||
               (m_ctrl[4] && (m_ovf || m_ferr));
    endfunction

    task automatic apb(input bit wr, input logic [3:0] a, input logic [31:0] wd,
                       input int max_wait, output logic [31:0] rd, output logic err,
                       output int waits, output bit ok);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        #1;
        waits = 0;
        while (pready !== 1'b1 && waits < max_wait) begin
            @(negedge clk);
            #1;
            waits++;
        end
        ok  = (pready === 1'b1);
        rd  = prdata;
        err = pslverr;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd; logic err; int w; bit ok;
        apb(1'b1, a, d, 20, rd, err, w, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL apb_write_timeout: addr %h pready 0 after %0d waits, want 1", a, w); end
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] rd);
        logic err; int w; bit ok;
        apb(1'b0, a, 32'h0, 20, rd, err, w, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL apb_read_timeout: addr %h pready 0 after %0d waits, want 1", a, w); end
    endtask

    task automatic set_ctrl(input logic [4:0] v);
        apb_write(4'hC, {27'd0, v});
        m_ctrl = v;
    endtask

    task automatic tx_write(input logic [31:0] w);
        apb_write(4'h0, w);
        for (int i = 0; i < BPW; i++) tx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic rx_byte(input logic [7:0] b, input bit e);
        @(negedge clk);
        rx_data = b; rx_err = e; rx_done = 1'b1;
        if (m_ctrl[1]) begin
            if (e) m_ferr = 1'b1;
            if (rx_q.size() >= RXD) m_ovf = 1'b1;
            else rx_q.push_back(b);
        end
        @(negedge clk);
        rx_done = 1'b0; rx_err = 1'b0;
    endtask

    function automatic logic [31:0] pop_rx_word();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < BPW; i++) w[8*i +: 8] = rx_q.pop_front();
        return w;
    endfunction

    task automatic check_status(input string name);
        logic [31:0] rd, ex;
        apb_read(4'h8, rd);
        ex = exp_status();
        checks++;
        if (rd !== ex) begin failures++; $display("FAIL %s: status got %h want %h", name, rd, ex); end
    endtask

    task automatic wait_tx_log(input int n);
        for (int c = 0; c < 3000 && tx_log.size() < n; c++) @(negedge clk);
        checks++;
        if (tx_log.size() != n) begin failures++; $display("FAIL tx_byte_count: got %0d want %0d", tx_log.size(), n); end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pready, pslverr, tx_start, irq, tx_en, rx_en} !== 6'b0 || prdata !== 32'h0 || tx_data !== 8'h0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy%b err%b st%b irq%b ten%b ren%b prdata %h tx_data %h want all 0",
                     pready, pslverr, tx_start, irq, tx_en, rx_en, prdata, tx_data);
        end
        rst_n = 1'b1;
        check_status("reset_status");
        apb_read(4'hC, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h want 0", rd); end
    endtask

    task automatic test_tx();
        logic [7:0] exp_stream[$];
        logic [31:0] w, rd; logic err; int waits; bit ok;
        set_ctrl(5'd0);
        tx_log.delete();
        done_delay = 0;
        for (int k = 0; k < TXD / BPW; k++) begin
            w = (k == 0) ? 32'h44332211 : $urandom;
            tx_write(w);
            for (int i = 0; i < BPW; i++) exp_stream.push_back(w[8*i +: 8]);
        end
        check_status("tx_full_status");
        apb(1'b1, 4'h0, $urandom, 6, rd, err, waits, ok);
`ifdef APB_UART_PSLVERR_EN
        checks++;
        if (!(ok && err === 1'b1)) begin failures++; $display("FAIL tx_full_err: ready %b pslverr %b want 1 1", ok, err); end
`else
        checks++;
        if (ok) begin failures++; $display("FAIL tx_full_stall: write completed after %0d waits, want wait states", waits); end
`endif
        check_status("tx_full_unchanged");
        set_ctrl(5'd1);
        wait_tx_log(TXD);
        for (int i = 0; i < TXD; i++) begin
            checks++;
            if (tx_log[i] !== exp_stream[i]) begin failures++; $display("FAIL tx_byte[%0d]: got %h want %h", i, tx_log[i], exp_stream[i]); end
        end
        tx_q.delete();
        check_status("tx_drained_status");
        set_ctrl(5'd0);
    endtask

    task automatic test_tx_en_clear();
        logic [31:0] w;
        tx_log.delete();
        done_delay = 12;
        w = $urandom;
        tx_write(w);
        set_ctrl(5'd1);
        wait_tx_log(1);
        set_ctrl(5'd0);
        repeat (40) @(negedge clk);
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== w[7:0]) begin
            failures++; $display("FAIL tx_en_clear: got %0d bytes first %h want 1 byte %h", tx_log.size(), tx_log[0], w[7:0]);
        end
        void'(tx_q.pop_front());
        check_status("tx_en_clear_status");
        done_delay = 0;
        set_ctrl(5'd1);
        wait_tx_log(4);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (tx_log[i] !== w[8*i +: 8]) begin failures++; $display("FAIL tx_resume[%0d]: got %h want %h", i, tx_log[i], w[8*i +: 8]); end
        end
        tx_q.delete();
        set_ctrl(5'd0);
    endtask

    task automatic test_rx();
        logic [31:0] rd, ex;
        logic [7:0] b;
        rx_byte(8'h5A, 1'b0);  // rx_en still 0: must be ignored
        check_status("rx_disabled_status");
        set_ctrl(5'd2);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < BPW; i++) begin
                b = (r == 0) ? 8'((i + 10) * 16 + i + 1) : 8'($urandom);
                rx_byte(b, 1'b0);
            end
            apb_read(4'h4, rd);
            ex = pop_rx_word();
            checks++;
            if (rd !== ex) begin failures++; $display("FAIL rx_word[%0d]: got %h want %h", r, rd, ex); end
            if (r == 0) begin
                checks++;
                if (rd !== 32'hD4C3B2A1) begin failures++; $display("FAIL rx_known_word: got %h want d4c3b2a1", rd); end
            end
            check_status("rx_empty_status");
        end
    endtask

    task automatic test_rx_stall();
        logic [31:0] rd, ex; logic err; int waits; bit ok;
        logic [7:0] b2, b3;
        set_ctrl(5'd2);
        rx_byte(8'($urandom), 1'b0);
        rx_byte(8'($urandom), 1'b0);
        b2 = 8'($urandom);
        b3 = 8'($urandom);
`ifdef APB_UART_PSLVERR_EN
        apb(1'b0, 4'h4, 32'h0, 5, rd, err, waits, ok);
        checks++;
        if (!(ok && err === 1'b1 && waits == 0 && rd === 32'h0)) begin
            failures++; $display("FAIL rx_short_err: ready %b pslverr %b waits %0d prdata %h want 1 1 0 0", ok, err, waits, rd);
        end
        check_status("rx_short_unchanged");
        rx_byte(b2, 1'b0);
        rx_byte(b3, 1'b0);
        apb_read(4'h4, rd);
`else
        fork
            apb(1'b0, 4'h4, 32'h0, 60, rd, err, waits, ok);
            begin
                repeat (6) @(negedge clk);
                rx_byte(b2, 1'b0);
                rx_byte(b3, 1'b0);
            end
        join
        checks++;
        if (!ok || waits < 5) begin failures++; $display("FAIL rx_short_stall: ready %b waits %0d want 1 and >=5", ok, waits); end
`endif
        ex = pop_rx_word();
        checks++;
        if (rd !== ex) begin failures++; $display("FAIL rx_stall_word: got %h want %h", rd, ex); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd, ex;
        set_ctrl(5'b10010);
        for (int i = 0; i < RXD + 1; i++) rx_byte(8'($urandom), 1'b0);
        check_status("ovf_status");
        checks++;
        if (irq !== 1'b1 || exp_irq() !== 1'b1) begin failures++; $display("FAIL ovf_irq: got %b want 1", irq); end
        apb_write(4'h8, 32'h0);
        check_status("ovf_w0_keeps");
        apb_write(4'h8, 32'h1 << 20);
        m_ovf = 1'b0;
        check_status("ovf_w1c");
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL ovf_irq_cleared: got %b want %b", irq, exp_irq()); end
        for (int k = 0; k < RXD / BPW; k++) begin
            apb_read(4'h4, rd);
            ex = pop_rx_word();
            checks++;
            if (rd !== ex) begin failures++; $display("FAIL ovf_drain[%0d]: got %h want %h", k, rd, ex); end
        end
    endtask

    task automatic test_ferr();
        logic [31:0] rd, ex;
        set_ctrl(5'b10010);
        rx_byte(8'($urandom), 1'b1);
        for (int i = 1; i < BPW; i++) rx_byte(8'($urandom), 1'b0);
        check_status("ferr_status");
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL ferr_irq: got %b want %b", irq, exp_irq()); end
        apb_read(4'h4, rd);
        ex = pop_rx_word();
        checks++;
        if (rd !== ex) begin failures++; $display("FAIL ferr_word: got %h want %h", rd, ex); end
        apb_write(4'h8, 32'h1 << 21);
        m_ferr = 1'b0;
        check_status("ferr_w1c");
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        set_ctrl(5'b00110);
        for (int i = 0; i < BPW - 1; i++) rx_byte(8'($urandom), 1'b0);
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL irq_rx_below: got %b want %b", irq, exp_irq()); end
        rx_byte(8'($urandom), 1'b0);
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL irq_rx_word: got %b want %b", irq, exp_irq()); end
        apb_read(4'h4, rd);
        void'(pop_rx_word());
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL irq_rx_read: got %b want %b", irq, exp_irq()); end
        set_ctrl(5'b01000);
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL irq_tx_empty: got %b want %b", irq, exp_irq()); end
        tx_log.delete();
        tx_write($urandom);
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL irq_tx_pending: got %b want %b", irq, exp_irq()); end
        set_ctrl(5'b01001);
        wait_tx_log(BPW);
        tx_q.delete();
        checks++;
        if (irq !== exp_irq()) begin failures++; $display("FAIL irq_tx_drained: got %b want %b", irq, exp_irq()); end
        set_ctrl(5'd0);
    endtask

    task automatic test_undef();
        logic [3:0] undef_list[12];
        logic [31:0] rd; logic err; int waits; bit ok;
        logic [4:0] v;
        undef_list = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF};
        v = 5'($urandom_range(0, 31)) & 5'b11110;
        set_ctrl(v);
        for (int k = 0; k < 4; k++) begin
            logic [3:0] a;
            a = undef_list[$urandom_range(0, 11)];
            apb(1'b0, a, 32'h0, 5, rd, err, waits, ok);
            checks++;
`ifdef APB_UART_PSLVERR_EN
            if (!ok || rd !== 32'h0 || err !== 1'b1) begin
                failures++; $display("FAIL undef_read %h: ready %b prdata %h pslverr %b want 1 0 1", a, ok, rd, err);
            end
`else
            if (!ok || rd !== 32'h0 || err !== 1'b0) begin
                failures++; $display("FAIL undef_read %h: ready %b prdata %h pslverr %b want 1 0 0", a, ok, rd, err);
            end
`endif
            apb(1'b1, a, $urandom, 5, rd, err, waits, ok);
        end
        apb_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL txdata_read: got %h want 0", rd); end
        apb_read(4'hC, rd);
        checks++;
        if (rd !== {27'd0, m_ctrl}) begin failures++; $display("FAIL ctrl_after_undef: got %h want %h", rd, m_ctrl); end
        checks++;
        if (irq !== exp_irq() || tx_en !== m_ctrl[0] || rx_en !== m_ctrl[1]) begin
            failures++; $display("FAIL ctrl_outputs: irq %b ten %b ren %b want %b %b %b", irq, tx_en, rx_en, exp_irq(), m_ctrl[0], m_ctrl[1]);
        end
        check_status("undef_status");
        set_ctrl(5'd0);
    endtask

    task automatic test_reset_mid_byte();
        logic [31:0] w;
        auto_done = 1'b0;
        tx_log.delete();
        set_ctrl(5'd2);
        rx_byte(8'($urandom), 1'b0);
        rx_byte(8'($urandom), 1'b0);
        tx_write($urandom);
        set_ctrl(5'd3);
        wait_tx_log(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({tx_start, tx_en, rx_en, irq} !== 4'b0 || tx_data !== 8'h0) begin
            failures++; $display("FAIL reset_mid_byte: st %b ten %b ren %b irq %b tx_data %h want 0", tx_start, tx_en, rx_en, irq, tx_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete(); rx_q.delete(); m_ctrl = 5'd0; m_ovf = 1'b0; m_ferr = 1'b0;
        check_status("reset_mid_byte_status");
        auto_done = 1'b1;
        tx_log.delete();
        set_ctrl(5'd1);
        w = $urandom;
        apb_write(4'h0, w);
        wait_tx_log(BPW);
        for (int i = 0; i < BPW; i++) begin
            checks++;
            if (tx_log[i] !== w[8*i +: 8]) begin failures++; $display("FAIL post_reset_tx[%0d]: got %h want %h", i, tx_log[i], w[8*i +: 8]); end
        end
        set_ctrl(5'd0);
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_en_clear();
        test_rx();
        test_rx_stall();
        test_overflow();
        test_ferr();
        test_irq();
        test_undef();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_uart_bridge.md
APB_UART_BRIDGE -- requirements
Module: apb_uart_bridge

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 16, TX byte FIFO depth (power of 2, >=4).
REQ-002 SHALL have parameter RX_DEPTH, default 16, RX byte FIFO depth (power of 2, >=4).
REQ-003 SHALL have parameter BYTES_PER_WORD, default 4, bytes packed per APB data access (1..4).
REQ-004 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  psel  in  1  APB select
  penable  in  1  APB access phase
  pwrite  in  1  1=write, 0=read
  paddr  in  4  register offset (word aligned)
  pwdata  in  32  write data
  prdata  out  32  read data
  pready  out  1  APB ready
  pslverr  out  1  APB error (active only with APB_UART_PSLVERR_EN)
  tx_data  out  8  byte to UART transmitter
  tx_start  out  1  one-cycle start pulse
  tx_done  in  1  transmitter finished byte
  rx_data  in  8  received byte
  rx_done  in  1  one-cycle valid for rx_data
  rx_err  in  1  framing/parity error with rx_done
  tx_en  out  1  transmitter enable (CTRL[0])
  rx_en  out  1  receiver enable (CTRL[1])
  irq  out  1  level interrupt

Function
REQ-005 SHALL decode offsets: 0x0 TXDATA (W), 0x4 RXDATA (R), 0x8 STATUS (R, W1C sticky bits), 0xC CTRL (R/W: [0] tx_en, [1] rx_en, [2] ie_rx, [3] ie_tx, [4] ie_err).
REQ-006 SHALL complete every access in its access phase (psel & penable); pready high that cycle unless REQ-008/009 stall.
REQ-007 SHALL push TXDATA bytes pwdata[7:0] first, up to BYTES_PER_WORD bytes, in one cycle.
REQ-008 SHALL accept a TXDATA write only if TX free space >= BYTES_PER_WORD; otherwise insert wait states (pready=0) until space exists.
REQ-009 SHALL complete an RXDATA read only if RX level >= BYTES_PER_WORD; otherwise insert wait states; first-received byte in prdata[7:0], unused upper bits 0.
REQ-010 STATUS SHALL be [5:0] tx_level, [13:8] rx_level (saturating display), [16] tx_empty, [17] tx_full, [18] rx_empty, [19] rx_full, [20] rx_ovf sticky, [21] rx_ferr sticky.
REQ-011 TX FSM SHALL be IDLE -> LOAD -> WAIT_DONE -> IDLE: IDLE leaves when tx_en=1 and TX FIFO non-empty; LOAD pops one byte onto tx_data and pulses tx_start one cycle; WAIT_DONE holds tx_data until tx_done, then IDLE.
REQ-012 tx_en cleared mid-byte SHALL let WAIT_DONE finish; no further pops.
REQ-013 rx_done with rx_en=1 SHALL push rx_data; rx_done with RX full SHALL drop byte and set rx_ovf; rx_done with rx_err SHALL set rx_ferr and still push.
REQ-014 Simultaneous push and pop on a full FIFO SHALL perform pop; push only if space existed before the cycle; simultaneous on empty FIFO SHALL not pop.
REQ-015 irq SHALL be (ie_rx & rx_level>=BYTES_PER_WORD) | (ie_tx & tx_empty) | (ie_err & (rx_ovf|rx_ferr)).
REQ-016 Undefined offsets SHALL read 0 and ignore writes.

Reset
REQ-017 rst_n low SHALL empty both FIFOs, FSM to IDLE, CTRL=0, sticky bits 0, outputs prdata=0, pready=0, pslverr=0, tx_start=0, tx_data=0, irq=0, tx_en=0, rx_en=0; mid-byte reset abandons byte.

Configuration
REQ-018 With APB_UART_PSLVERR_EN defined, REQ-008/009 stall conditions and undefined offsets SHALL instead complete immediately with pready=1, pslverr=1, no FIFO change; without it, pslverr SHALL be constant 0 and stalls apply.

Structure
REQ-019 Package apb_uart_pkg SHALL hold register offsets, STATUS/CTRL bit positions and TX FSM state enum.
REQ-020 Sub-module apb_uart_byte_fifo (parametrised depth, push/pop/level/full/empty) SHALL be instantiated twice.

Verification
REQ-021 Write 0x44332211 to TXDATA, tx_en=1 -> tx_data 0x11,0x22,0x33,0x44 in order, one tx_start per tx_done.
REQ-022 Inject rx bytes 0xA1,0xB2,0xC3,0xD4, read RXDATA -> prdata 0xD4C3B2A1, rx_empty=1.
REQ-023 Read RXDATA with 2 bytes queued -> pready low until 2 more bytes arrive (macro off); pready=1,pslverr=1 (macro on).
REQ-024 RX_DEPTH+1 bytes without reads -> rx_ovf=1, irq=1 with ie_err; write 1 to STATUS[20] clears it.
REQ-025 Assert rst_n=0 during WAIT_DONE -> next cycle FSM IDLE, FIFOs empty, tx_start=0.
